simple_cpu_io_ctrl: RTL and testbench
=====================================

# simple_cpu_io_ctrl

Board-side I/O and run controller for the SimpleCPU on the BeMicro MAX10. It sequences the CPU reset, releasing it after a hold-off and re-asserting it on a debounced PB0 press. It debounces PB3..PB1 and forwards button-state changes to the CPU input port as single-cycle write strobes. It drives the eight user LEDs from a registered slice of the CPU output port.

## Interface
- DEBOUNCE_CYCLES, 50000: consecutive stable synchronized cycles required to accept a button level change (≥2)
- HOLD_CYCLES, 16: cycles cpu_reset stays high after leaving RESET or after a PB0 press (≥1)
- LED_LSB, 16: lowest port_out_out bit shown on the LEDs (0..24)
- clk  in  1  system clock; the only clock
- reset  in  1  asynchronous, active-high reset
- pb_n  in  4  raw push buttons, active-low, asynchronous to clk
- cpu_reset  out  1  synchronous reset to SimpleCPU, active-high
- port_in_in  out  32  data to the CPU input port
- port_in_we  out  1  one-cycle write strobe for port_in_in
- port_out_out  in  32  CPU output port value
- led_n  out  8  user LEDs, active-low

## Operation
- Input path: each pb_n bit passes through a 2-flop synchronizer, then a per-button debouncer. The debounced output is pressed[i] (1 = pressed).
- Debouncer behaviour:
  - Counter clears whenever the synced level equals the current debounced level.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1 while the mismatch persists, the debounced level flips on that edge.
  - press_evt[i] pulses for one cycle on each 0→1 flip.
- Reset FSM, states RESET, HOLD, RUN:
  - Async reset forces RESET.
  - RESET→HOLD on the first clk edge with reset low.
  - In HOLD, hold_cnt counts 0..HOLD_CYCLES-1, then the FSM moves to RUN.
  - RUN→HOLD on press_evt[0].
  - press_evt[0] while in HOLD clears hold_cnt, which restarts the hold-off.
  - cpu_reset = 1 in RESET and HOLD, 0 in RUN. It is a registered output.
- Button reporting (RUN only):
  - last_rep[2:0] is cleared to 0 while in HOLD.
  - In RUN, if pressed[3:1] ≠ last_rep, the block asserts port_in_we for one cycle with port_in_in = {29'd0, pressed[3:1]}, and last_rep takes that value.
  - A change arriving during a strobe cycle is reported on the following cycle.
  - port_in_in holds its last reported value between strobes.
  - port_in_we is never asserted while cpu_reset = 1.
- LED path: led_n = 8'hFF while cpu_reset = 1; otherwise led_n = ~port_out_out[LED_LSB+7:LED_LSB], registered.

## Timing
- Reset values:
  - cpu_reset = 1
  - port_in_in = 0
  - port_in_we = 0
  - led_n = 8'hFF
  - all pressed = 0, all counters = 0, state = RESET
- Reset mid-operation: everything returns to the reset values asynchronously, including a pending strobe, which is dropped.
- Button latency: a clean pb_n edge reaches pressed[] after 2 (sync) + DEBOUNCE_CYCLES cycles. A strobe follows 1 cycle later if in RUN.
- Bounce: any return to the old level before DEBOUNCE_CYCLES clears the counter, and no flip occurs.
- Reset release: cpu_reset falls HOLD_CYCLES+1 edges after the first clk edge with reset low.
- First report: if buttons are already held when RUN is entered, the strobe occurs on the first RUN cycle, because last_rep = 0 differs from pressed.
- Simultaneous events:
  - press_evt[0] in the same cycle as a pending report: the FSM goes to HOLD and the report is suppressed.
  - Several buttons changing together produce one strobe carrying all bits.
- LED latency: 1 cycle from port_out_out to led_n.

## Structure
- Package simple_cpu_io_pkg holds:
  - state enum (RESET, HOLD, RUN)
  - port_in field width constant BTN_W = 3
  - LED_W = 8
- Sub-module pb_debounce (synchronizer + counter + press_evt), instantiated 4× by generate. Counter width is $clog2(DEBOUNCE_CYCLES).

## Test plan
Run with DEBOUNCE_CYCLES=8, HOLD_CYCLES=4.
- Reset sequence: assert reset, release → cpu_reset=1 for exactly 5 edges, then 0; led_n=8'hFF until release, then ~port_out_out[23:16].
- Clean press: drive pb_n[1]=0 → after 10 cycles, one port_in_we with port_in_in=32'h1; release → strobe with 32'h0.
- Bounce: toggle pb_n[2] with periods shorter than 8 cycles, then settle low → exactly one strobe with 32'h2, after settling + 10 cycles.
- PB0 press in RUN: cpu_reset rises after debounce and holds 4 cycles; a second press mid-HOLD extends it; no strobe while cpu_reset=1.
- Buttons held through hold-off: pb_n[3:1]=3'b000 during HOLD → a single strobe 32'h7 on the first RUN cycle.
- Async reset during a strobe cycle → port_in_we drops immediately, all outputs take their reset values.

Source files
------------

// File: rtl/simple_cpu_io_pkg.sv
// simple_cpu_io_pkg
// Shared types and constants for the SimpleCPU board I/O controller:
// run-control FSM state encoding, button/LED field widths and a helper
// that packs the reported button bits into the CPU input-port word.
package simple_cpu_io_pkg;

  localparam int BTN_W  = 3;  // PB3..PB1 reported to the CPU
  localparam int LED_W  = 8;  // user LEDs on the board
  localparam int NUM_PB = 4;  // PB3..PB0

  // Run-control states; explicit encodings keep the legacy state values.
  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_HOLD  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Zero-extend the reported button bits to the 32-bit input-port word.
  function automatic logic [31:0] btn_word(input logic [BTN_W-1:0] btn);
    btn_word = {29'd0, btn};
  endfunction

endpackage

// File: rtl/simple_cpu_io_ctrl_pb_debounce.sv
// pb_debounce
// One push button: 2-flop synchronizer on the raw active-low input,
// followed by a stability counter. The debounced level only changes after
// DEBOUNCE_CYCLES consecutive synchronized cycles that disagree with it.
// Ports:
//   clk       system clock
//   reset     asynchronous active-high reset
//   pb_n      raw button, active-low, asynchronous to clk
//   pressed   debounced level, 1 = pressed
//   press_evt one-cycle pulse on each released->pressed flip
module pb_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic pb_n,
  output logic pressed,
  output logic press_evt
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_r;
  logic             level_s;
  logic [CNT_W-1:0] cnt_r;
  logic             pressed_r;
  logic             evt_r;

  // Two-stage synchronizer; resets to the released (high) level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], pb_n};
    end
  end

  assign level_s = ~sync_r[1];

  // Stability counter: the flip happens on the edge where the counter is
  // already at its maximum and the mismatch is still present.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r     <= '0;
      pressed_r <= 1'b0;
      evt_r     <= 1'b0;
    end else if (level_s == pressed_r) begin
      cnt_r <= '0;
      evt_r <= 1'b0;
    end else if (cnt_r == CNT_MAX) begin
      cnt_r     <= '0;
      pressed_r <= level_s;
      evt_r     <= level_s;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
      evt_r <= 1'b0;
    end
  end

  assign pressed   = pressed_r;
  assign press_evt = evt_r;

endmodule

// File: rtl/simple_cpu_io_ctrl.sv
// simple_cpu_io_ctrl
// Board-side run and I/O controller for SimpleCPU on the BeMicro MAX10.
// Holds the CPU in reset for a hold-off after power-up or a PB0 press,
// reports PB3..PB1 level changes to the CPU input port as one-cycle write
// strobes, and mirrors an 8-bit slice of the CPU output port on the LEDs.
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   pb_n[3:0]    raw push buttons, active-low
//   cpu_reset    registered synchronous reset to the CPU, active-high
//   port_in_in   data word for the CPU input port (holds last report)
//   port_in_we   one-cycle write strobe for port_in_in
//   port_out_out CPU output port value
//   led_n[7:0]   user LEDs, active-low
module simple_cpu_io_ctrl
  import simple_cpu_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 16,
  parameter int LED_LSB         = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  pb_n,
  output logic        cpu_reset,
  output logic [31:0] port_in_in,
  output logic        port_in_we,
  input  logic [31:0] port_out_out,
  output logic [7:0]  led_n
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);

  logic [NUM_PB-1:0] pressed_s;
  logic [NUM_PB-1:0] press_evt_s;

  state_e            state_r;
  state_e            state_nxt_s;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [HOLD_W-1:0] hold_cnt_nxt_s;
  logic [BTN_W-1:0]  last_rep_r;
  logic [BTN_W-1:0]  last_rep_nxt_s;
  logic              run_nxt_s;
  logic              report_s;

  logic              cpu_reset_r;
  logic [31:0]       port_in_r;
  logic              port_in_we_r;
  logic [LED_W-1:0]  led_r;

  // Only PB0's press event and PB3..PB1 levels feed the logic.
  logic              unused_s;
  assign unused_s = ^{port_out_out, pressed_s[0], press_evt_s[3:1]};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PB; gi++) begin : g_pb
      pb_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_pb (
        .clk      (clk),
        .reset    (reset),
        .pb_n     (pb_n[gi]),
        .pressed  (pressed_s[gi]),
        .press_evt(press_evt_s[gi])
      );
    end
  endgenerate

  // Run-control next state: a PB0 press restarts the hold-off from RUN or HOLD.
  always_comb begin
    state_nxt_s    = state_r;
    hold_cnt_nxt_s = hold_cnt_r;
    case (state_r)
      ST_RESET: begin
        state_nxt_s    = ST_HOLD;
        hold_cnt_nxt_s = '0;
      end
      ST_HOLD: begin
        if (press_evt_s[0]) begin
          hold_cnt_nxt_s = '0;
        end else if (hold_cnt_r == HOLD_MAX) begin
          state_nxt_s    = ST_RUN;
          hold_cnt_nxt_s = '0;
        end else begin
          hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        if (press_evt_s[0]) begin
          state_nxt_s    = ST_HOLD;
          hold_cnt_nxt_s = '0;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s    = ST_RESET;
        hold_cnt_nxt_s = '0;
      end
    endcase
  end

  // All outputs are registered from the next state, so cpu_reset, the LED
  // blanking and the strobe gating change on the same edge and a strobe can
  // never coincide with cpu_reset high. This also places the first report on
  // the first RUN cycle, and a PB0 press in RUN suppresses a pending report.
  always_comb begin
    run_nxt_s = (state_nxt_s == ST_RUN);
    report_s  = run_nxt_s && (pressed_s[3:1] != last_rep_r);
    if (!run_nxt_s) begin
      last_rep_nxt_s = '0;
    end else if (report_s) begin
      last_rep_nxt_s = pressed_s[3:1];
    end else begin
      last_rep_nxt_s = last_rep_r;
    end
  end

  // FSM and report-tracking state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_RESET;
      hold_cnt_r <= '0;
      last_rep_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      hold_cnt_r <= hold_cnt_nxt_s;
      last_rep_r <= last_rep_nxt_s;
    end
  end

  // Output registers; port_in_in keeps its value between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_reset_r  <= 1'b1;
      port_in_r    <= 32'd0;
      port_in_we_r <= 1'b0;
      led_r        <= 8'hFF;
    end else begin
      cpu_reset_r  <= ~run_nxt_s;
      port_in_we_r <= report_s;
      if (report_s) begin
        port_in_r <= btn_word(pressed_s[3:1]);
      end else begin
        port_in_r <= port_in_r;
      end
      if (run_nxt_s) begin
        led_r <= ~port_out_out[LED_LSB +: LED_W];
      end else begin
        led_r <= 8'hFF;
      end
    end
  end

  assign cpu_reset  = cpu_reset_r;
  assign port_in_in = port_in_r;
  assign port_in_we = port_in_we_r;
  assign led_n      = led_r;

endmodule

// File: tb/tb_simple_cpu_io_ctrl.sv
// Bench for simple_cpu_io_ctrl with DEBOUNCE_CYCLES=8, HOLD_CYCLES=4.
// Expected strobe words are queued by the stimulus; a monitor pops one on
// every port_in_we. A second instance with a long hold-off shows that a
// PB0 press during HOLD restarts the hold-off.
module tb_simple_cpu_io_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  pb_n = 4'hF;
  logic [31:0] port_out_out = 32'h00A5_0000;

  logic        cpu_reset;
  logic [31:0] port_in_in;
  logic        port_in_we;
  logic [7:0]  led_n;

  logic        l_cpu_reset;
  logic [31:0] l_port_in_in;
  logic        l_port_in_we;
  logic [7:0]  l_led_n;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  simple_cpu_io_ctrl #(
    .DEBOUNCE_CYCLES(8), .HOLD_CYCLES(4), .LED_LSB(16)
  ) dut (
    .clk(clk), .reset(reset), .pb_n(pb_n), .cpu_reset(cpu_reset),
    .port_in_in(port_in_in), .port_in_we(port_in_we),
    .port_out_out(port_out_out), .led_n(led_n)
  );

  simple_cpu_io_ctrl #(
    .DEBOUNCE_CYCLES(8), .HOLD_CYCLES(30), .LED_LSB(16)
  ) dut_long (
    .clk(clk), .reset(reset), .pb_n(pb_n), .cpu_reset(l_cpu_reset),
    .port_in_in(l_port_in_in), .port_in_we(l_port_in_we),
    .port_out_out(port_out_out), .led_n(l_led_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Move to just after the next rising edge, where inputs are driven.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Count rising edges until port_in_we is seen; 0 means it never came.
  task automatic wait_we(input string name, input int exp_n);
    int n;
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (port_in_we) n = i;
    end
    chk(name, n, exp_n);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!reset && port_in_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got %h expected none at %0t", port_in_in, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("strobe_data", port_in_in, mon_exp);
        chk("strobe_cpu_reset", {31'd0, cpu_reset}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic me, le;
    // Reset state.
    step(3);
    @(negedge clk);
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_port_in_in", port_in_in, 32'd0);
    chk("rst_port_in_we", {31'd0, port_in_we}, 32'd0);
    chk("rst_led_n", {24'd0, led_n}, 32'h0000_00FF);

    // Release: cpu_reset high through edge 4, low from edge 5.
    step(1);
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rel_cpu_reset", {31'd0, cpu_reset}, {31'd0, (k < 5)});
      chk("rel_led_n", {24'd0, led_n}, (k < 5) ? 32'h0000_00FF : 32'h0000_005A);
    end
    port_out_out = 32'h003C_0000;
    @(posedge clk);
    @(negedge clk);
    chk("led_follow", {24'd0, led_n}, 32'h0000_00C3);

    // Clean press/release of PB1.
    step(1);
    exp_q.push_back(32'h1);
    pb_n = 4'b1101;
    wait_we("press1_latency", 11);
    step(3);
    chk("port_in_hold", port_in_in, 32'h1);
    chk("we_single", {31'd0, port_in_we}, 32'd0);
    exp_q.push_back(32'h0);
    pb_n = 4'b1111;
    wait_we("release1_latency", 11);

    // Bounce on PB2, every stretch shorter than the debounce window.
    step(2);
    pb_n = 4'b1011; step(3);
    pb_n = 4'b1111; step(2);
    pb_n = 4'b1011; step(5);
    pb_n = 4'b1111; step(1);
    exp_q.push_back(32'h2);
    pb_n = 4'b1011;
    wait_we("bounce_latency", 11);
    step(1);
    exp_q.push_back(32'h0);
    pb_n = 4'b1111;
    wait_we("bounce_release", 11);

    // PB0 press in RUN, then release and re-press during the long hold-off.
    step(2);
    pb_n = 4'b1110;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk);
      #1;
      if (n == 11) pb_n = 4'b1111;
      if (n == 22) pb_n = 4'b1110;
      @(negedge clk);
      me = ((n >= 11) && (n < 15)) || ((n >= 33) && (n < 37));
      le = (n >= 11) && (n < 63);
      chk("pb0_cpu_reset", {31'd0, cpu_reset}, {31'd0, me});
      chk("pb0_led_n", {24'd0, led_n}, me ? 32'h0000_00FF : 32'h0000_00C3);
      chk("pb0_hold_extend", {31'd0, l_cpu_reset}, {31'd0, le});
    end
    step(1);
    pb_n = 4'b1111;
    step(15);

    // All buttons together: PB0 event suppresses the report, then a single
    // strobe of 7 on the first RUN cycle.
    exp_q.push_back(32'h7);
    pb_n = 4'b0000;
    wait_we("held_first_run", 15);
    step(1);
    exp_q.push_back(32'h0);
    pb_n = 4'b1111;
    wait_we("held_release", 11);

    // Async reset in the middle of a strobe cycle.
    step(2);
    exp_q.push_back(32'h1);
    pb_n = 4'b1101;
    wait_we("pre_reset_strobe", 11);
    #1;
    reset = 1'b1;
    #1;
    chk("areset_we", {31'd0, port_in_we}, 32'd0);
    chk("areset_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("areset_port_in", port_in_in, 32'd0);
    chk("areset_led_n", {24'd0, led_n}, 32'h0000_00FF);
    pb_n = 4'b1111;
    step(3);
    reset = 1'b0;
    step(5);
    @(negedge clk);
    chk("rerun_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    step(20);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
